// File: rtl/dbg_display_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : dbg_display_ctrl_if
// Purpose  : Datapath/controller-to-board-I/O signal bundle for dbg_display_ctrl.
//            Optional macro DBG_HEX_MODE_EN adds the HEXMODE select.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface dbg_display_ctrl_if #(
  parameter int DATA_W     = 10,
  parameter int NUM_DIGITS = 4,
  parameter int TIME_W     = 2
);
  logic [DATA_W-1:0]       BUS;
  logic [DATA_W-1:0]       REG;
  logic [TIME_W-1:0]       TIME;
  logic                    DONE;
  logic                    Pkb;
  logic                    HOLD;
`ifdef DBG_HEX_MODE_EN
  logic                    HEXMODE;
`endif
  logic [DATA_W-1:0]       LED_B;
  logic [7*NUM_DIGITS-1:0] DHEX;
  logic [6:0]              THEX;
  logic                    LED_D;
  logic                    BUSY;

`ifdef DBG_HEX_MODE_EN
  modport master (
    output BUS, REG, TIME, DONE, Pkb, HOLD, HEXMODE,
    input  LED_B, DHEX, THEX, LED_D, BUSY
  );
  modport slave (
    input  BUS, REG, TIME, DONE, Pkb, HOLD, HEXMODE,
    output LED_B, DHEX, THEX, LED_D, BUSY
  );
`else
  modport master (
    output BUS, REG, TIME, DONE, Pkb, HOLD,
    input  LED_B, DHEX, THEX, LED_D, BUSY
  );
  modport slave (
    input  BUS, REG, TIME, DONE, Pkb, HOLD,
    output LED_B, DHEX, THEX, LED_D, BUSY
  );
`endif

endinterface

`default_nettype wire

// File: rtl/dbg_display_ctrl.sv
//------------------------------------------------------------------------------
// Module   : dbg_display_ctrl
// Purpose  : Registered debug display: BUS/REG peek converted to decimal by a
//            sequential double-dabble engine, bus LEDs, timestep digit and a
//            stretched done LED. Macro DBG_HEX_MODE_EN adds a raw-hex display.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dbg_display_ctrl #(
  parameter int DATA_W       = 10,
  parameter int NUM_DIGITS   = 4,
  parameter int TIME_W       = 2,
  parameter int DONE_STRETCH = 4
) (
  input  logic                CLK,
  input  logic                RSTb,
  dbg_display_ctrl_if.slave   dbg
);

  localparam int         c_bcd_w    = 4 * NUM_DIGITS;
  localparam int         c_cnt_w    = $clog2(DATA_W + 1);
  localparam int         c_str_w    = $clog2(DONE_STRETCH + 1);
  localparam logic [6:0] c_seg_zero = 7'b1000000;

  // True when NUM_DIGITS decimal digits can hold the largest DATA_W value.
  function automatic bit f_digits_ok();
    longint unsigned v_pow;
    longint unsigned v_max;
    v_pow = 1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v_pow < 64'd100000000000000000) v_pow = v_pow * 10;
    end
    v_max = (64'd1 << DATA_W) - 1;
    return v_pow > v_max;
  endfunction

  localparam bit c_digits_ok = f_digits_ok();

  if (!c_digits_ok) begin : g_err_digits
    $error("dbg_display_ctrl: NUM_DIGITS too small for DATA_W");
  end
  if ((1 << TIME_W) > 10) begin : g_err_time
    $error("dbg_display_ctrl: TIME_W too wide for one decimal digit");
  end
  if (DONE_STRETCH < 1) begin : g_err_stretch
    $error("dbg_display_ctrl: DONE_STRETCH must be >= 1");
  end

  function automatic logic [6:0] f_seg7(input logic [3:0] v);
    f_seg7 = 7'b1111111;
    case (v)
      4'h0: f_seg7 = 7'b1000000;
      4'h1: f_seg7 = 7'b1111001;
      4'h2: f_seg7 = 7'b0100100;
      4'h3: f_seg7 = 7'b0110000;
      4'h4: f_seg7 = 7'b0011001;
      4'h5: f_seg7 = 7'b0010010;
      4'h6: f_seg7 = 7'b0000010;
      4'h7: f_seg7 = 7'b1111000;
      4'h8: f_seg7 = 7'b0000000;
      4'h9: f_seg7 = 7'b0010000;
      4'hA: f_seg7 = 7'b0001000;
      4'hB: f_seg7 = 7'b0000011;
      4'hC: f_seg7 = 7'b1000110;
      4'hD: f_seg7 = 7'b0100001;
      4'hE: f_seg7 = 7'b0000110;
      4'hF: f_seg7 = 7'b0001110;
    endcase
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;

  logic [DATA_W-1:0]       r_shreg;
  logic [DATA_W-1:0]       r_last_src;
  logic [c_bcd_w-1:0]      r_bcd;
  logic [c_cnt_w-1:0]      r_bit_cnt;
  logic [7*NUM_DIGITS-1:0] r_dhex;
  logic [DATA_W-1:0]       r_led_b;
  logic [6:0]              r_thex;
  logic [c_str_w-1:0]      r_str_cnt;
  logic                    r_led_d;

  logic [DATA_W-1:0]       w_src;
  logic                    w_hex_sel;
  logic                    w_src_changed;
  logic                    w_load;
  logic [c_bcd_w-1:0]      w_bcd_adj;
  logic [7*NUM_DIGITS-1:0] w_dhex_seg;
  logic [c_str_w-1:0]      w_str_next;

  assign w_src = dbg.Pkb ? dbg.BUS : dbg.REG;

`ifdef DBG_HEX_MODE_EN
  logic r_last_hex;

  assign w_hex_sel     = dbg.HEXMODE;
  assign w_src_changed = (w_src != r_last_src) || (dbg.HEXMODE != r_last_hex);

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_last_hex <= 1'b0;
    end else if (w_load) begin
      r_last_hex <= dbg.HEXMODE;
    end
  end
`else
  assign w_hex_sel     = 1'b0;
  assign w_src_changed = (w_src != r_last_src);
`endif

  assign w_load = (r_state == ST_IDLE) && !dbg.HOLD && w_src_changed;

  // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_adj
    assign w_bcd_adj[4*k +: 4] = (r_bcd[4*k +: 4] >= 4'd5) ? (r_bcd[4*k +: 4] + 4'd3)
                                                           : r_bcd[4*k +: 4];
    assign w_dhex_seg[7*k +: 7] = f_seg7(r_bcd[4*k +: 4]);
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_load) w_state_next = w_hex_sel ? ST_COMMIT : ST_CONV;
      end
      ST_CONV: begin
        if (r_bit_cnt == c_cnt_w'(1)) w_state_next = ST_COMMIT;
      end
      ST_COMMIT: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_shreg    <= '0;
      r_last_src <= '0;
      r_bcd      <= '0;
      r_bit_cnt  <= '0;
      r_dhex     <= {NUM_DIGITS{c_seg_zero}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_load) begin
            r_shreg    <= w_src;
            r_last_src <= w_src;
            r_bcd      <= w_hex_sel ? c_bcd_w'(w_src) : '0;
            r_bit_cnt  <= c_cnt_w'(DATA_W);
          end
        end
        ST_CONV: begin
          r_bcd     <= (w_bcd_adj << 1) | c_bcd_w'(r_shreg[DATA_W-1]);
          r_shreg   <= r_shreg << 1;
          r_bit_cnt <= r_bit_cnt - c_cnt_w'(1);
        end
        ST_COMMIT: r_dhex <= w_dhex_seg;
        default: ;
      endcase
    end
  end

  // LED_D is decoded from the next count so it drops the cycle after DONE.
  assign w_str_next = dbg.DONE          ? c_str_w'(DONE_STRETCH) :
                      (r_str_cnt != '0) ? (r_str_cnt - c_str_w'(1)) : '0;

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_led_b   <= '0;
      r_thex    <= c_seg_zero;
      r_str_cnt <= '0;
      r_led_d   <= 1'b1;
    end else begin
      r_led_b   <= dbg.BUS;
      r_thex    <= f_seg7(4'(dbg.TIME));
      r_str_cnt <= w_str_next;
      r_led_d   <= (w_str_next == '0);
    end
  end

  assign dbg.LED_B = r_led_b;
  assign dbg.DHEX  = r_dhex;
  assign dbg.THEX  = r_thex;
  assign dbg.LED_D = r_led_d;
  assign dbg.BUSY  = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_dbg_display_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_dbg_display_ctrl
// Purpose  : Directed bench for dbg_display_ctrl with an event-timer model.
//            Exercises the raw-hex path when DBG_HEX_MODE_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dbg_display_ctrl;

  localparam int DATA_W       = 10;
  localparam int NUM_DIGITS   = 4;
  localparam int TIME_W       = 2;
  localparam int DONE_STRETCH = 4;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S7 = 7'b1111000, S9 = 7'b0010000, SA = 7'b0001000,
                         SF = 7'b0001110;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  dbg_display_ctrl_if #(.DATA_W(DATA_W), .NUM_DIGITS(NUM_DIGITS), .TIME_W(TIME_W)) bus_if ();

  dbg_display_ctrl #(
    .DATA_W(DATA_W), .NUM_DIGITS(NUM_DIGITS), .TIME_W(TIME_W), .DONE_STRETCH(DONE_STRETCH)
  ) dut (
    .CLK  (clk),
    .RSTb (rst_n),
    .dbg  (bus_if.slave)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  function automatic logic [7*NUM_DIGITS-1:0] render(input int v, input bit hexm);
    int p;
    int d;
    render = '0;
    p = 1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      d = hexm ? ((v >> (4*k)) & 15) : ((v / p) % 10);
      render[7*k +: 7] = seg_tab[d];
      p = p * 10;
    end
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a display update is a countdown of edges from the sampled change.
  int                      m_cd        = 0;
  int                      m_last      = 0;
  int                      m_pend      = 0;
  bit                      m_hex_pend  = 0;
  bit                      m_hex_last  = 0;
  logic [7*NUM_DIGITS-1:0] m_dhex      = {NUM_DIGITS{7'b1000000}};
  logic [DATA_W-1:0]       m_led_b     = '0;
  logic [6:0]              m_thex      = 7'b1000000;
  logic                    m_led_d     = 1'b1;
  int                      m_edge      = 0;
  int                      m_last_done = -1000;

  always @(posedge clk or negedge rst_n) begin
    int  src;
    bit  hexm;
    if (!rst_n) begin
      m_cd = 0; m_last = 0; m_hex_last = 0;
      m_dhex = {NUM_DIGITS{7'b1000000}};
      m_led_b = '0; m_thex = 7'b1000000; m_led_d = 1'b1;
      m_last_done = -1000;
    end else begin
      src  = bus_if.Pkb ? int'(bus_if.BUS) : int'(bus_if.REG);
`ifdef DBG_HEX_MODE_EN
      hexm = bus_if.HEXMODE;
`else
      hexm = 1'b0;
`endif
      if (m_cd == 0) begin
        if (!bus_if.HOLD && (src != m_last || hexm != m_hex_last)) begin
          m_last = src; m_hex_last = hexm;
          m_pend = src; m_hex_pend = hexm;
          m_cd   = hexm ? 2 - 1 : DATA_W + 1;
        end
      end else begin
        m_cd--;
        if (m_cd == 0) m_dhex = render(m_pend, m_hex_pend);
      end
      m_led_b = bus_if.BUS;
      m_thex  = seg_tab[int'(bus_if.TIME)];
      m_edge++;
      if (bus_if.DONE) m_last_done = m_edge;
      m_led_d = !((m_edge - m_last_done) < DONE_STRETCH);
    end
  end

  always @(negedge clk) begin
    check("dhex",  32'(bus_if.DHEX),  32'(m_dhex));
    check("thex",  32'(bus_if.THEX),  32'(m_thex));
    check("led_b", 32'(bus_if.LED_B), 32'(m_led_b));
    check("led_d", 32'(bus_if.LED_D), 32'(m_led_d));
    check("busy",  32'(bus_if.BUSY),  32'(m_cd != 0));
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  localparam logic [6:0] c_t_exp [4] = '{S0, S1, S2, S3};

  initial begin
    bus_if.BUS = '0; bus_if.REG = '0; bus_if.TIME = '0;
    bus_if.DONE = 1'b0; bus_if.Pkb = 1'b0; bus_if.HOLD = 1'b0;
`ifdef DBG_HEX_MODE_EN
    bus_if.HEXMODE = 1'b0;
`endif
    tick(3);
    rst_n = 1'b1;
    tick(3);
    check("lit_reset_dhex", 32'(bus_if.DHEX), 32'({S0, S0, S0, S0}));
    check("lit_zero_idle",  32'(bus_if.BUSY), 32'd0);
    check("lit_reset_ledd", 32'(bus_if.LED_D), 32'd1);

    // 1023 on BUS: decimal 1,0,2,3 after twelve edges
    bus_if.Pkb = 1'b1; bus_if.BUS = 10'd1023;
    tick(1);
    check("lit_busy_rise", 32'(bus_if.BUSY), 32'd1);
    check("lit_led_b",     32'(bus_if.LED_B), 32'd1023);
    tick(10);
    check("lit_1023_early", 32'(bus_if.DHEX), 32'({S0, S0, S0, S0}));
    tick(1);
    check("lit_1023", 32'(bus_if.DHEX), 32'({S1, S0, S2, S3}));

    // REG 517, changed to 42 during the third conversion cycle
    bus_if.Pkb = 1'b0; bus_if.REG = 10'd517;
    tick(3);
    bus_if.REG = 10'd42;
    tick(9);
    check("lit_517", 32'(bus_if.DHEX), 32'({S0, S5, S1, S7}));
    tick(12);
    check("lit_42", 32'(bus_if.DHEX), 32'({S0, S0, S4, S2}));

    // HOLD raised mid-conversion, then source changes while frozen
    bus_if.Pkb = 1'b1; bus_if.BUS = 10'd77;
    tick(2);
    bus_if.HOLD = 1'b1;
    tick(13);
    check("lit_77_hold", 32'(bus_if.DHEX), 32'({S0, S0, S7, S7}));
    bus_if.BUS = 10'd5;
    tick(3);
    bus_if.BUS = 10'd900;
    tick(3);
    check("lit_hold_frozen", 32'(bus_if.DHEX), 32'({S0, S0, S7, S7}));
    check("lit_hold_idle",   32'(bus_if.BUSY), 32'd0);
    bus_if.HOLD = 1'b0;
    tick(12);
    check("lit_900", 32'(bus_if.DHEX), 32'({S0, S9, S0, S0}));

    // Single DONE pulse: low for cycles 1..4
    bus_if.DONE = 1'b1; tick(1); bus_if.DONE = 1'b0;
    check("lit_ledd_fall", 32'(bus_if.LED_D), 32'd0);
    tick(3);
    check("lit_ledd_c4", 32'(bus_if.LED_D), 32'd0);
    tick(1);
    check("lit_ledd_c5", 32'(bus_if.LED_D), 32'd1);
    tick(2);

    // Retrigger on cycle 3 stretches low period to cycle 7
    bus_if.DONE = 1'b1; tick(1); bus_if.DONE = 1'b0;
    tick(2);
    bus_if.DONE = 1'b1; tick(1); bus_if.DONE = 1'b0;
    tick(3);
    check("lit_ledd_c7", 32'(bus_if.LED_D), 32'd0);
    tick(1);
    check("lit_ledd_c8", 32'(bus_if.LED_D), 32'd1);

    for (int t = 0; t < 4; t++) begin
      bus_if.TIME = TIME_W'(t);
      tick(1);
      check("lit_thex", 32'(bus_if.THEX), 32'(c_t_exp[t]));
    end

    // Asynchronous reset in the middle of a conversion and a stretch
    bus_if.BUS = 10'd300; bus_if.DONE = 1'b1;
    tick(1);
    bus_if.DONE = 1'b0;
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    check("lit_arst_dhex",  32'(bus_if.DHEX),  32'({S0, S0, S0, S0}));
    check("lit_arst_thex",  32'(bus_if.THEX),  32'(S0));
    check("lit_arst_led_b", 32'(bus_if.LED_B), 32'd0);
    check("lit_arst_led_d", 32'(bus_if.LED_D), 32'd1);
    check("lit_arst_busy",  32'(bus_if.BUSY),  32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(12);
    check("lit_300", 32'(bus_if.DHEX), 32'({S0, S3, S0, S0}));

`ifdef DBG_HEX_MODE_EN
    bus_if.HEXMODE = 1'b1; bus_if.BUS = 10'h2AF;
    tick(2);
    check("lit_hex_2af", 32'(bus_if.DHEX), 32'({S0, S2, SA, SF}));
    bus_if.HEXMODE = 1'b0;
    tick(12);
    check("lit_dec_687", 32'(bus_if.DHEX), 32'(render(687, 1'b0)));
`endif

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dbg_display_ctrl.md
Name: dbg_display_ctrl

Overview:
Parametrised, registered successor to the processor's combinational output/debug display logic. Selects BUS or REG using the peek control Pkb. Converts the selected value to decimal with a sequential double-dabble engine and drives NUM_DIGITS active-low 7-segment digits. Also registers the bus LEDs, decodes the timestep to THEX, and stretches the instruction-done indication so that it is visible on an LED. Sits between the processor datapath/controller and board I/O.

Parameters:
DATA_W, 10, width of BUS/REG/LED_B.
NUM_DIGITS, 4, number of decimal digits on DHEX. Must satisfy 10^NUM_DIGITS > 2^DATA_W - 1; a violation raises an elaboration-time $error.
TIME_W, 2, timestep width. 2^TIME_W must be <= 10.
DONE_STRETCH, 4, number of cycles LED_D stays active after a DONE pulse; must be >= 1.

Ports:
CLK  in  1  clock, rising edge.
RSTb  in  1  asynchronous, active-low reset.
BUS  in  DATA_W  shared data bus.
REG  in  DATA_W  register file read port 2.
TIME  in  TIME_W  controller timestep.
DONE  in  1  instruction-complete (Clr) from the controller, active-high.
Pkb  in  1  1 = display BUS, 0 = display REG.
HOLD  in  1  1 = freeze DHEX; no new conversions start.
LED_B  out  DATA_W  registered copy of BUS.
DHEX  out  7*NUM_DIGITS  active-low gfedcba segments; digit k occupies bits [7k+6:7k]; k=0 is the least significant digit.
THEX  out  7  registered timestep digit.
LED_D  out  1  active-low done LED.
BUSY  out  1  1 while a conversion is in flight.

Behaviour:
Reset (RSTb=0, asynchronous):
- LED_B=0.
- Every DHEX digit shows "0" (7'b1000000).
- THEX=7'b1000000.
- LED_D=1.
- BUSY=0.
- FSM=IDLE.
- last_src=0.
- Stretch counter=0.

LED_B and THEX:
- LED_B <= BUS every cycle (1-cycle latency).
- THEX <= seg(TIME) every cycle (1-cycle latency).

Segment table (active-low):
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.

Source:
- src = Pkb ? BUS : REG, combinational.

FSM states: IDLE, CONV, COMMIT.
- IDLE: if HOLD=0 and src != last_src, latch src into the shift register and into last_src, clear the BCD accumulator, set bit counter=DATA_W, then go to CONV. Otherwise stay in IDLE.
- CONV: each cycle, add 3 to every BCD nibble that is >= 5, then shift {bcd, shreg} left by 1 and decrement the counter. When the counter reaches 0 after the shift, go to COMMIT.
- COMMIT: DHEX <= seg(bcd digits), then go to IDLE.
- Latency from a src change being sampled in IDLE to the DHEX update is DATA_W+2 edges (12 at default).
- BUSY=1 in CONV and COMMIT.

Boundary conditions:
- src changes during CONV or COMMIT: the in-flight conversion completes with the old sample. The new value is picked up in IDLE on the next cycle if it still differs from last_src.
- A Pkb toggle is simply a src change.
- HOLD asserted mid-conversion: the conversion completes and commits. No new load occurs while HOLD=1. On HOLD release, a new load occurs if src != last_src.
- All-zero input after reset: no conversion is needed because reset already displays 0.
- Leading zeros are displayed (not blanked).

DONE stretch:
- DONE=1 in a cycle loads the counter with DONE_STRETCH. Otherwise the counter decrements while nonzero.
- LED_D = (counter == 0), registered.
- LED_D falls 1 cycle after DONE and remains 0 for DONE_STRETCH cycles after the last DONE.
- Stretch is retriggerable: DONE during an active stretch reloads the counter.
- Reset mid-stretch clears it immediately.

Reset mid-conversion:
- Aborts the conversion; all outputs return to their reset values.

Optional Feature:
Macro DBG_HEX_MODE_EN.
- When defined: adds input port HEXMODE (1 bit).
  - With HEXMODE=1, the IDLE load path skips CONV and goes straight to COMMIT. DHEX then shows raw hexadecimal nibbles of the latched src, zero-extended to 4*NUM_DIGITS bits (latency 2 edges).
  - A HEXMODE change counts as a source change and forces a reconversion.
- When undefined: the port is absent and the display is decimal only.

Test Plan:
- Reset check: assert RSTb=0 mid-run -> all DHEX digits 1000000, THEX 1000000, LED_B=0, LED_D=1, BUSY=0, all asynchronously.
- Pkb=1, BUS=1023 -> BUSY rises; exactly 12 edges later DHEX digits 3..0 = 1,0,2,3 (0011001 on digit1 checked for 2? no: digit1=0100100 "2", digit0=0110000 "3"); LED_B=1023 after 1 edge.
- Pkb=0, REG=517, then REG=42 on the third CONV cycle -> DHEX shows 0517, then 0042 is committed 12 edges after the next IDLE cycle.
- HOLD=1 with BUS changing 5 -> 900 -> DHEX unchanged; release HOLD -> DHEX shows 0900 after 12 edges.
- DONE_STRETCH=4, one-cycle DONE pulse -> LED_D low for cycles 1..4 after the pulse; a second DONE on cycle 3 extends the low period to cycle 7.
- With DBG_HEX_MODE_EN, HEXMODE=1, BUS=0x2AF -> DHEX shows 0,2,A,F two edges later.
